// File: rtl/ahb_sram_subordinate_pkg.sv
// Shared AHB definitions: bus widths, htrans/hresp encodings and the SRAM
// subordinate FSM states.
package AhbGlobalPackage;

    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned HPROT_WIDTH = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        SRAM_IDLE,
        SRAM_WAIT,
        SRAM_ERR1,
        SRAM_ERR2
    } sram_state_e;

endpackage

// File: rtl/ahb_sram_bytemem.sv
// Word-organised storage with per-byte write enables, combinational read
// and asynchronous clear of every word.
module ahb_sram_bytemem
    import AhbGlobalPackage::*;
#(
    parameter int unsigned MEM_DEPTH = 16,
    parameter int unsigned IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [IDX_W-1:0]        addr,
    input  logic [DATA_WIDTH/8-1:0] strb,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (strb[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB subordinate fronting a small SRAM: fixed wait states per OKAY transfer,
// two-cycle ERROR response for out-of-range, oversized or misaligned accesses.
module ahb_sram_subordinate
    import AhbGlobalPackage::*;
#(
    parameter int unsigned MEM_DEPTH   = 16,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    input  logic                    hselx,
    input  logic [ADDR_WIDTH-1:0]   haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [2:0]              hburst,
    input  logic [HPROT_WIDTH-1:0]  hprot,
    input  logic [DATA_WIDTH-1:0]   hwdata,
    input  logic [DATA_WIDTH/8-1:0] hwstrb,
    input  logic                    hready,
    output logic                    hreadyout,
    output logic                    hresp,
    output logic [DATA_WIDTH-1:0]   hrdata,
    output logic                    hexokay
);

    localparam int unsigned NB        = DATA_WIDTH / 8;
    localparam int unsigned BL        = $clog2(NB);
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
    localparam int unsigned MEM_BYTES = MEM_DEPTH * NB;

    sram_state_e             state, state_n;
    logic [3:0]              cnt, cnt_n;
    logic                    dphase;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [2:0]              size_q;
    logic [NB-1:0]           strb_q;

    logic                    accept;
    logic                    misalign;
    logic                    xfer_err;
    logic                    done;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    unused_ok;

    assign accept = hselx && hready && hreadyout &&
                    (htrans inside {HTRANS_NONSEQ, HTRANS_SEQ});

    always_comb begin
        misalign = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if ((i < 32'(hsize)) && haddr[i]) begin
                misalign = 1'b1;
            end
        end
    end

    assign xfer_err = misalign || (hsize > 3'(BL)) ||
                      (haddr >= ADDR_WIDTH'(MEM_BYTES));

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= SRAM_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            SRAM_IDLE, SRAM_ERR2: begin
                state_n = SRAM_IDLE;
                if (accept) begin
                    if (xfer_err) begin
                        state_n = SRAM_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_n = SRAM_WAIT;
                        cnt_n   = 4'(WAIT_STATES);
                    end
                end
            end
            SRAM_WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_n = SRAM_IDLE;
                end
            end
            SRAM_ERR1: state_n = SRAM_ERR2;
            default:   state_n = SRAM_IDLE;
        endcase
    end

    // A data phase completes in the IDLE cycle that follows an accepted OKAY transfer.
    always_comb begin
        hreadyout = !((state == SRAM_WAIT) || (state == SRAM_ERR1));
        hresp     = ((state == SRAM_ERR1) || (state == SRAM_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        done      = (state == SRAM_IDLE) && dphase;
        mem_we    = done && write_q;
        hrdata    = (done && !write_q) ? mem_rdata : '0;
        hexokay   = 1'b0;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dphase  <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            strb_q  <= '0;
        end else if (accept) begin
            dphase  <= !xfer_err;
            addr_q  <= haddr;
            write_q <= hwrite;
            size_q  <= hsize;
            strb_q  <= hwstrb;
        end else if (done) begin
            dphase  <= 1'b0;
        end
    end

    ahb_sram_bytemem #(
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk   (hclk),
        .rst_n (hresetn),
        .we    (mem_we),
        .addr  (addr_q[BL +: IDX_W]),
        .strb  (strb_q),
        .wdata (hwdata),
        .rdata (mem_rdata)
    );

    assign unused_ok = ^{hburst, hprot, size_q, addr_q[BL-1:0],
                         addr_q[ADDR_WIDTH-1:BL+IDX_W]};

endmodule

// File: doc/ahb_sram_subordinate.md
AHB_SRAM_SUBORDINATE -- requirements
Module: ahb_sram_subordinate

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 16, number of DATA_WIDTH-bit words stored.
REQ-002 SHALL have parameter WAIT_STATES, default 2, wait cycles inserted per OKAY transfer, legal range 0..15.
REQ-003 SHALL use one clock; reset is asynchronous and active-low; ports: hclk input 1, rising-edge clock; hresetn input 1, async active-low reset.
REQ-004 SHALL have ports, one per entry:
  - hselx input 1: subordinate select.
  - haddr input ADDR_WIDTH: byte address.
  - htrans input 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
  - hwrite input 1: 1=write.
  - hsize input 3: log2 of bytes per transfer.
  - hburst input 3: burst type, not decoded.
  - hprot input HPROT_WIDTH: not decoded.
  - hwdata input DATA_WIDTH: write data.
  - hwstrb input DATA_WIDTH/8: byte lane enables.
  - hready input 1: bus-level ready from the interconnect.
  - hreadyout output 1: this subordinate's ready.
  - hresp output 1: 0=OKAY, 1=ERROR.
  - hrdata output DATA_WIDTH: read data.
  - hexokay output 1: tied 0.

Function
REQ-005 SHALL accept an address phase only when hselx=1, hready=1 and htrans is NONSEQ or SEQ; SHALL register haddr, hwrite, hsize and hwstrb at that edge.
REQ-006 SHALL answer IDLE or BUSY, or hselx=0, with a zero-wait OKAY and no memory access.
REQ-007 SHALL flag a transfer as an error when any of these holds:
  - haddr >= MEM_DEPTH*(DATA_WIDTH/8);
  - hsize > log2(DATA_WIDTH/8);
  - haddr is not aligned to 2^hsize.
REQ-008 SHALL implement an FSM with states IDLE, WAIT, ERR1 and ERR2.
REQ-009 IDLE transitions: accepted error transfer -> ERR1; accepted OKAY transfer with WAIT_STATES>0 -> WAIT with the counter loaded to WAIT_STATES; accepted OKAY transfer with WAIT_STATES=0 -> stay in IDLE, with the data phase completing next cycle.
REQ-010 WAIT: hreadyout=0 and hresp=0; counter decrements each cycle; at counter=1 SHALL move to IDLE, and the data phase completes in that following cycle with hreadyout=1.
REQ-011 ERR1: hreadyout=0, hresp=1, then unconditionally -> ERR2; ERR2: hreadyout=1, hresp=1, then -> IDLE, and SHALL accept a new address phase in the ERR2 cycle per REQ-005.
REQ-012 A write SHALL update memory word haddr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)] at the edge ending the data phase with hreadyout=1, writing only the byte lanes with hwstrb=1, using hwdata sampled at that edge.
REQ-013 A read SHALL drive hrdata with the full addressed word in every data-phase cycle where hreadyout=1; hrdata SHALL be 0 outside read data phases and during error responses.
REQ-014 An error transfer SHALL never modify memory.
REQ-015 A back-to-back address phase presented in the completing data-phase cycle (hreadyout=1) SHALL be accepted with no bubble.
REQ-016 A read following a write to the same word SHALL return the new data.
REQ-017 No new address phase SHALL be accepted while hready=0.

Reset
REQ-018 While hresetn=0: FSM = IDLE, counter = 0, hreadyout=1, hresp=0, hrdata=0, hexokay=0, all memory words = 0.
REQ-019 Reset asserted mid-transfer (WAIT or ERR1/ERR2) SHALL abort it immediately with no memory write; after release the block SHALL be in IDLE with hreadyout=1.

Structure
REQ-020 ADDR_WIDTH, DATA_WIDTH and HPROT_WIDTH, plus an htrans enum, an hresp enum and the FSM state enum, SHALL come from AhbGlobalPackage; the FSM enum SHALL be added there.
REQ-021 Storage SHALL be a sub-module ahb_sram_bytemem: MEM_DEPTH words, per-byte write enable, asynchronous read, asynchronous clear.

Verification (DATA_WIDTH=32, MEM_DEPTH=16, WAIT_STATES=2)
REQ-022 Write 0xDEADBEEF to 0x08 with hwstrb=0xF, then read 0x08 -> each data phase shows 2 cycles hreadyout=0 then OKAY; read returns 0xDEADBEEF.
REQ-023 Write 0x000000AA to 0x08 with hwstrb=0x1, then read 0x08 -> 0xDEADBEAA.
REQ-024 Read 0x40 (out of range) -> hresp=1 with hreadyout=0 for one cycle, then hresp=1 with hreadyout=1 for one cycle; memory unchanged.
REQ-025 hsize=2 at 0x06 (misaligned) -> two-cycle ERROR; write data discarded.
REQ-026 Four back-to-back NONSEQ writes to 0x0,0x4,0x8,0xC, then reset asserted during the WAIT of the 4th -> 0xC stays 0, other words are 0 after reset, hreadyout=1 one cycle after release.
REQ-027 htrans=BUSY with hselx=1 -> hreadyout=1, hresp=0 with no wait, memory unchanged.
